// File: rtl/watch_pkg.sv
// Shared definitions for the watch datapath: packed time layout and the alarm FSM states.
package watch_pkg;

  localparam int TIME_W    = 52;
  localparam int YEAR_MSB  = 51;
  localparam int YEAR_LSB  = 40;
  localparam int MONTH_MSB = 39;
  localparam int MONTH_LSB = 32;
  localparam int DAY_MSB   = 31;
  localparam int DAY_LSB   = 24;
  localparam int HOUR_MSB  = 23;
  localparam int HOUR_LSB  = 16;
  localparam int MIN_MSB   = 15;
  localparam int MIN_LSB   = 8;
  localparam int SEC_MSB   = 7;
  localparam int SEC_LSB   = 0;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RING,
    CLEAR,
    HOLD
  } alarm_state_t;

  // Builds a packed timestamp in the same layout the alarm setter uses.
  function automatic logic [TIME_W-1:0] pack_time(
    input logic [11:0] year,
    input logic [7:0]  month,
    input logic [7:0]  day,
    input logic [7:0]  hour,
    input logic [7:0]  minute,
    input logic [7:0]  second
  );
    logic [TIME_W-1:0] t;
    t = '0;
    t[YEAR_MSB:YEAR_LSB]   = year;
    t[MONTH_MSB:MONTH_LSB] = month;
    t[DAY_MSB:DAY_LSB]     = day;
    t[HOUR_MSB:HOUR_LSB]   = hour;
    t[MIN_MSB:MIN_LSB]     = minute;
    t[SEC_MSB:SEC_LSB]     = second;
    return t;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a slow asynchronous level, plus a one-cycle pulse
// on each synchronized rising edge.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic pulse
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= d;
      level <= meta;
      prev  <= level;
    end
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: compares current time to the stored alarm, rings with a gated
// tone, and asks the alarm setter to clear on dismiss or timeout.
module alarm_trigger
  import watch_pkg::*;
#(
  parameter int RING_SEC = 60,
  parameter int TONE_DIV = 25000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk1sec,
  input  logic [3:0]        sw_in,
  input  logic [11:0]       year,
  input  logic [7:0]        month,
  input  logic [7:0]        day,
  input  logic [7:0]        hour,
  input  logic [7:0]        minute,
  input  logic [7:0]        second,
  input  logic [TIME_W-1:0] bin_alarm,
  output logic              ringing,
  output logic              buzzer,
  output logic              rst_alarm
);

  localparam int RS_W = $clog2(RING_SEC + 1);
  localparam int TN_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [RS_W-1:0] RS_LAST = RS_W'(RING_SEC - 1);
  localparam logic [RS_W-1:0] RS_MAX  = RS_W'(RING_SEC);
  localparam logic [TN_W-1:0] TN_LAST = TN_W'(TONE_DIV - 1);

  logic [TIME_W-1:0] now;
  logic              sec_level;
  logic              tick;
  logic              alarm_set;
  logic              alarm_hit;
  logic              dismiss;
  logic              timeout;

  alarm_state_t      state;
  logic [RS_W-1:0]   ring_sec;
  logic [TN_W-1:0]   tone_cnt;
  logic              tone;

  assign now       = pack_time(year, month, day, hour, minute, second);
  assign alarm_set = |bin_alarm;
  assign alarm_hit = (now == bin_alarm);
  assign dismiss   = |sw_in;
  assign timeout   = tick && (ring_sec == RS_LAST);

  sync_edge u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (clk1sec),
    .level (sec_level),
    .pulse (tick)
  );

  // Outputs default low every cycle and are re-asserted only by the state that
  // owns them, so ringing tracks RING and rst_alarm lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ringing   <= 1'b0;
      rst_alarm <= 1'b0;
      ring_sec  <= '0;
      tone_cnt  <= '0;
      tone      <= 1'b0;
    end else begin
      ringing   <= 1'b0;
      rst_alarm <= 1'b0;
      tone_cnt  <= '0;
      tone      <= 1'b0;
      case (state)
        IDLE: begin
          if (alarm_set) state <= ARMED;
        end
        ARMED: begin
          if (!alarm_set) begin
            state <= IDLE;
          end else if (alarm_hit) begin
            state    <= RING;
            ringing  <= 1'b1;
            ring_sec <= '0;
          end
        end
        RING: begin
          if (!alarm_set) begin
            state <= IDLE;
          end else if (dismiss || timeout) begin
            state     <= CLEAR;
            rst_alarm <= 1'b1;
          end else begin
            ringing  <= 1'b1;
            tone_cnt <= (tone_cnt == TN_LAST) ? '0 : tone_cnt + 1'b1;
            tone     <= (tone_cnt == TN_LAST) ? ~tone : tone;
          end
          if (tick && (ring_sec != RS_MAX)) ring_sec <= ring_sec + 1'b1;
        end
        CLEAR: begin
          state <= HOLD;
        end
        // Wait for the setter to drop the alarm so the old value cannot re-fire.
        HOLD: begin
          if (!alarm_set) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign buzzer = tone & sec_level & ringing;

endmodule

// File: tb/tb_alarm_trigger.sv
// Randomized bench for alarm_trigger: a behavioural model predicts output
// changes into a queue, and a monitor pairs them with the DUT's output changes.
module tb_alarm_trigger;

  localparam int RING_SEC = 3;
  localparam int TONE_DIV = 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        clk1sec   = 1'b0;
  logic [3:0]  sw_in     = 4'b0000;
  logic [11:0] year      = 12'd2024;
  logic [7:0]  month     = 8'd5;
  logic [7:0]  day       = 8'd1;
  logic [7:0]  hour      = 8'd7;
  logic [7:0]  minute    = 8'd30;
  logic [7:0]  second    = 8'd0;
  logic [51:0] bin_alarm = '0;
  logic        ringing;
  logic        buzzer;
  logic        rst_alarm;

  typedef struct {
    int         stamp;
    logic [2:0] vec;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  bit  m_armed, m_ring, m_clear, m_hold;
  int  m_ticks, m_rcyc;
  bit  s1, s2, s3;
  logic [2:0] m_vec = 3'b000;

  alarm_trigger #(.RING_SEC(RING_SEC), .TONE_DIV(TONE_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk1sec   (clk1sec),
    .sw_in     (sw_in),
    .year      (year),
    .month     (month),
    .day       (day),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .bin_alarm (bin_alarm),
    .ringing   (ringing),
    .buzzer    (buzzer),
    .rst_alarm (rst_alarm)
  );

  always #5 clk = ~clk;

  // The 1 Hz stand-in toggles off the clk grid so it never lands on an edge.
  initial begin
    #2;
    forever #60 clk1sec = ~clk1sec;
  end

  function automatic logic [51:0] pack_t(input int y, input int mo, input int d,
                                         input int h, input int mi, input int s);
    return (52'(y) << 40) | (52'(mo) << 32) | (52'(d) << 24) |
           (52'(h) << 16) | (52'(mi) << 8) | 52'(s);
  endfunction

  function automatic logic [51:0] now_packed();
    return pack_t(int'(year), int'(month), int'(day), int'(hour), int'(minute), int'(second));
  endfunction

  task automatic model_reset();
    m_armed = 0; m_ring = 0; m_clear = 0; m_hold = 0;
    m_ticks = 0; m_rcyc = 0;
    s1 = 0; s2 = 0; s3 = 0;
  endtask

  task automatic model_step();
    bit tick;
    tick = s2 && !s3;
    if (m_clear) begin
      m_clear = 0;
      m_hold  = 1;
    end else if (m_hold) begin
      if (bin_alarm == 0) m_hold = 0;
    end else if (m_ring) begin
      if (bin_alarm == 0) begin
        m_ring = 0;
      end else if (sw_in != 0 || (tick && m_ticks + 1 >= RING_SEC)) begin
        m_ring  = 0;
        m_clear = 1;
      end else begin
        if (tick) m_ticks++;
        m_rcyc++;
      end
    end else if (m_armed) begin
      if (bin_alarm == 0) begin
        m_armed = 0;
      end else if (now_packed() == bin_alarm) begin
        m_armed = 0;
        m_ring  = 1;
        m_ticks = 0;
        m_rcyc  = 0;
      end
    end else if (bin_alarm != 0) begin
      m_armed = 1;
    end
    s3 = s2;
    s2 = s1;
    s1 = clk1sec;
  endtask

  task automatic model_push();
    logic [2:0] v;
    bit tone;
    tone = ((m_rcyc / TONE_DIV) % 2) == 1;
    v = {m_ring, m_ring && tone && s2, m_clear};
    if (v != m_vec) begin
      exp_q.push_back('{stamp: int'(($time + 4) / 10), vec: v});
      m_vec = v;
    end
  endtask

  // Reference model: reacts to the clock and to asynchronous reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
      model_push();
    end
  end

  // Monitor: every change of the DUT output vector must match the next prediction.
  initial begin
    logic [2:0] prev;
    logic [2:0] cur;
    ev_t        e;
    int         stamp;
    prev = 3'b000;
    forever begin
      @(negedge clk);
      cur = {ringing, buzzer, rst_alarm};
      if (cur !== prev) begin
        stamp = int'($time / 10) - 1;
        checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_change: got %b at cycle %0d, expected no change", cur, stamp);
        end else begin
          e = exp_q.pop_front();
          if (e.stamp == stamp && e.vec === cur) passes++;
          else $display("[TB] FAIL output_event: got %b at cycle %0d, expected %b at cycle %0d",
                        cur, stamp, e.vec, e.stamp);
        end
        prev = cur;
      end
    end
  end

  task automatic check_output(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, act, req);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_now(input int y, input int mo, input int d, input int h, input int mi, input int s);
    year = 12'(y); month = 8'(mo); day = 8'(d); hour = 8'(h); minute = 8'(mi); second = 8'(s);
  endtask

  task automatic pulse_sw(input logic [3:0] v);
    sw_in = v;
    step(1);
    sw_in = 4'b0000;
  endtask

  task automatic finish_alarm();
    step(4);
    bin_alarm = '0;
    step(4);
  endtask

  // kind: 0 dismiss, 1 timeout, 2 dismiss on the final tick, 3 external clear
  task automatic apply_stimulus(input int kind);
    bit found;
    bin_alarm = now_packed();
    step(2);
    case (kind)
      0: begin
        step($urandom_range(1, 25));
        pulse_sw(4'b0001 << $urandom_range(0, 3));
        finish_alarm();
      end
      1: begin
        step(60);
        finish_alarm();
      end
      2: begin
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
          if (m_ring && s2 && !s3 && m_ticks == RING_SEC - 1) found = 1;
          else step(1);
        end
        if (!found) begin
          checks++;
          $display("[TB] FAIL final_tick_wait: got no final tick within 80 cycles, expected one");
        end else begin
          pulse_sw(4'b1000);
        end
        finish_alarm();
      end
      default: begin
        step($urandom_range(2, 15));
        bin_alarm = '0;
        step(5);
      end
    endcase
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check_output("reset_outputs", {ringing, buzzer, rst_alarm}, 3'b000);
    step(3);
    check_output("held_in_reset", {ringing, buzzer, rst_alarm}, 3'b000);
    @(negedge clk);
    #1 rst = 1'b1;
    step(3);

    $display("[TB] match at 2024/05/01 07:30:00, ring to timeout");
    set_now(2024, 5, 1, 7, 30, 0);
    apply_stimulus(1);

    $display("[TB] dismiss with sw_in=0010");
    bin_alarm = now_packed();
    step(8);
    pulse_sw(4'b0010);
    finish_alarm();

    $display("[TB] armed early, time advances into the alarm");
    set_now(2024, 5, 1, 7, 29, 58);
    bin_alarm = pack_t(2024, 5, 1, 7, 30, 0);
    step(5);
    set_now(2024, 5, 1, 7, 29, 59);
    step(3);
    set_now(2024, 5, 1, 7, 30, 0);
    step(10);
    pulse_sw(4'b0100);
    finish_alarm();

    $display("[TB] alarm in the past never fires");
    bin_alarm = pack_t(2024, 5, 1, 7, 29, 0);
    step(40);
    check_output("past_alarm_silent", {ringing, buzzer, rst_alarm}, {m_ring, 1'b0, m_clear});
    bin_alarm = '0;
    step(3);

    $display("[TB] simultaneous dismiss and timeout, then external clear");
    apply_stimulus(2);
    apply_stimulus(3);

    $display("[TB] reset while ringing");
    bin_alarm = now_packed();
    step(10);
    check_output("ringing_before_reset", {2'b00, ringing}, {2'b00, m_ring});
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("reset_mid_ring", {ringing, buzzer, rst_alarm}, 3'b000);
    bin_alarm = '0;
    step(3);
    @(negedge clk);
    #1 rst = 1'b1;
    step(6);
    check_output("idle_after_reset", {ringing, buzzer, rst_alarm}, 3'b000);
    apply_stimulus(0);

    $display("[TB] randomized alarms");
    repeat (12) begin
      set_now($urandom_range(2000, 2099), $urandom_range(1, 12), $urandom_range(1, 28),
              $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      apply_stimulus($urandom_range(0, 3));
    end

    step(5);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("[TB] FAIL leftover_events: got %0d unmatched predictions, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
